uart_fc_core: RTL and testbench

Parametrised, synthesizable UART transceiver with TX/RX FIFOs, configurable frame format and RTS/CTS hardware flow control. It is the on-chip counterpart of the simulation UART host and sits inside `top` between the SoC peripheral bus adapter and the `uart_tx`/`uart_rx`/`uart_rts`/`uart_cts` pads. Unlike the fixed 8N1 host model, it supports 5–8 data bits, optional parity, 1 or 2 stop bits, and reports errors per received character.

---
 rtl/uart_fc_core.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_fc_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fc_core.sv
// UART transceiver with TX/RX FIFOs, programmable frame format and RTS/CTS flow control.
// uart_tx goes through one extra output flop, so the first start bit appears two edges after the push.

module uart_fc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         full, do_push, do_pop;

  // The extra pointer MSB tells full from empty when the index bits match.
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wptr - rptr;
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module uart_fc_core #(
  parameter int FREQ       = 10000000,
  parameter int BAUD       = 100000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  output logic                 uart_rts,
  input  logic                 uart_cts
);
  localparam int DIV = FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(DIV / 2 - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] RTS_LVL   = LW'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == 1);
  endfunction

  // ---------------- synchronisers ----------------
  logic rx_meta, rx_s, rx_q, cts_meta, cts_s;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_q     <= 1'b1;
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      rx_meta  <= uart_rx;
      rx_s     <= rx_meta;
      rx_q     <= rx_s;
      cts_meta <= uart_cts;
      cts_s    <= cts_meta;
    end
  end

  assign rx_fall = rx_q && !rx_s;

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] tx_head, rx_head, rx_sh;
  logic                 tx_empty, rx_empty, tx_push, tx_pop, rx_push, rx_pop, rx_full;
  logic [LW-1:0]        tx_level, rx_level;

  assign tx_ready = (tx_level != FULL_LVL);
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_head;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_full  = (rx_level == FULL_LVL);

  uart_fc_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(tx_data),
    .dout(tx_head), .empty(tx_empty), .level(tx_level)
  );

  uart_fc_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .dout(rx_head), .empty(rx_empty), .level(rx_level)
  );

  // ---------------- transmitter ----------------
  state_t               tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;
  logic                 tx_stop, tx_par, tx_line, tx_last;
  logic [DATA_BITS-1:0] tx_sh;

  assign tx_last = (tx_cnt == BIT_END);
  // Pop from IDLE or at the end of the last stop bit, so queued frames run gap-free.
  assign tx_pop  = !tx_empty && cts_s &&
                   ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_last && tx_stop == LAST_STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_stop <= 1'b0;
      tx_par  <= 1'b0;
      tx_sh   <= '0;
      tx_line <= 1'b1;
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_line;
      if (tx_st != S_IDLE) tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
      case (tx_st)
        S_IDLE: if (tx_pop) begin
          tx_st   <= S_START;
          tx_sh   <= tx_head;
          tx_par  <= par_of(tx_head);
          tx_line <= 1'b0;
          tx_cnt  <= '0;
        end
        S_START: if (tx_last) begin
          tx_st   <= S_DATA;
          tx_bit  <= '0;
          tx_line <= tx_sh[0];
        end
        S_DATA: if (tx_last) begin
          if (tx_bit == LAST_DATA) begin
            tx_stop <= 1'b0;
            if (PARITY != 0) begin
              tx_st   <= S_PAR;
              tx_line <= tx_par;
            end else begin
              tx_st   <= S_STOP;
              tx_line <= 1'b1;
            end
          end else begin
            tx_bit  <= tx_bit + 3'd1;
            tx_sh   <= tx_sh >> 1;
            tx_line <= tx_sh[1];
          end
        end
        S_PAR: if (tx_last) begin
          tx_st   <= S_STOP;
          tx_stop <= 1'b0;
          tx_line <= 1'b1;
        end
        S_STOP: if (tx_last) begin
          if (tx_stop == LAST_STOP) begin
            if (tx_pop) begin
              tx_st   <= S_START;
              tx_sh   <= tx_head;
              tx_par  <= par_of(tx_head);
              tx_line <= 1'b0;
            end else begin
              tx_st   <= S_IDLE;
            end
          end else begin
            tx_stop <= tx_stop + 1'b1;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  state_t        rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_par, rx_last, rx_drop;

  assign rx_last = (rx_cnt == BIT_END);
  assign rx_push = (rx_st == S_STOP) && rx_last && rx_s;
  assign rx_drop = rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st         <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_cnt        <= (rx_st == S_IDLE || rx_last) ? '0 : rx_cnt + CW'(1);
      case (rx_st)
        S_IDLE: if (rx_fall) rx_st <= S_START;
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_last) begin
          rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST_DATA) rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
          else                     rx_bit <= rx_bit + 3'd1;
        end
        S_PAR: if (rx_last) begin
          rx_par <= rx_s;
          rx_st  <= S_STOP;
        end
        // A low stop bit returns to IDLE; the edge detector re-arms only once the line goes high.
        S_STOP: if (rx_last) begin
          rx_st        <= S_IDLE;
          rx_frame_err <= !rx_s;
          if (rx_s) begin
            rx_overrun    <= rx_drop;
            rx_parity_err <= (PARITY != 0) && !rx_drop && (rx_par != par_of(rx_sh));
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uart_rts <= 1'b1;
    else        uart_rts <= (rx_level <= RTS_LVL);
  end
endmodule

// File: tb/tb_uart_fc_core.sv
// Directed bench: 8N1 instance (A) for TX waveform, loopback, framing, overrun, CTS and reset;
// 7E1 instance (B) for receive parity checking.
module tb_uart_fc_core;
  localparam int DIV = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_txd = '0, a_rxd;
  logic a_txv = 1'b0, a_txr, a_rxv, a_rxr = 1'b0, a_perr, a_ferr, a_ovr;
  logic a_tx, a_rx, a_rts, a_cts = 1'b1;
  logic loop = 1'b1, drv_a = 1'b1;
  assign a_rx = loop ? a_tx : drv_a;

  logic [6:0] b_txd = '0, b_rxd;
  logic b_txv = 1'b0, b_txr, b_rxv, b_rxr = 1'b0, b_perr, b_ferr, b_ovr;
  logic b_tx, b_rts, drv_b = 1'b1;

  uart_fc_core #(.FREQ(10000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr),
    .rx_data(a_rxd), .rx_valid(a_rxv), .rx_ready(a_rxr), .rx_parity_err(a_perr),
    .rx_frame_err(a_ferr), .rx_overrun(a_ovr), .uart_tx(a_tx), .uart_rx(a_rx),
    .uart_rts(a_rts), .uart_cts(a_cts)
  );

  uart_fc_core #(.FREQ(10000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_txr),
    .rx_data(b_rxd), .rx_valid(b_rxv), .rx_ready(b_rxr), .rx_parity_err(b_perr),
    .rx_frame_err(b_ferr), .rx_overrun(b_ovr), .uart_tx(b_tx), .uart_rx(drv_b),
    .uart_rts(b_rts), .uart_cts(1'b1)
  );

  int vectors = 0, miscompares = 0;
  int n_perr_a = 0, n_ferr_a = 0, n_ovr_a = 0, n_perr_b = 0, n_ferr_b = 0, n_ovr_b = 0;
  int lowcnt = 0;

  always @(posedge clk) begin
    if (a_perr) n_perr_a++;
    if (a_ferr) n_ferr_a++;
    if (a_ovr)  n_ovr_a++;
    if (b_perr) n_perr_b++;
    if (b_ferr) n_ferr_b++;
    if (b_ovr)  n_ovr_b++;
    if (!a_tx)  lowcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to_b, input logic [9:0] fr);
    for (int i = 0; i < 10; i++) begin
      if (to_b) drv_b = fr[i]; else drv_a = fr[i];
      tick(DIV);
    end
    if (to_b) drv_b = 1'b1; else drv_a = 1'b1;
  endtask

  task automatic wait_rx(input bit b, input string tag, input int limit);
    int n = 0;
    while (!(b ? b_rxv : a_rxv) && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, b ? b_rxv : a_rxv, 1);
  endtask

  task automatic pop(input bit b, input string tag, input logic [7:0] exp);
    if (b) begin
      chk(tag, {1'b0, b_rxd}, exp);
      b_rxr = 1'b1; tick(1); b_rxr = 1'b0;
    end else begin
      chk(tag, a_rxd, exp);
      a_rxr = 1'b1; tick(1); a_rxr = 1'b0;
    end
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (a_tx && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, a_tx, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int l0, pe, fe, ov;

    // reset state
    tick(3);
    chk("rst_outs", {a_tx, a_rts, a_txr, a_rxv, b_tx, b_rts, b_txr, b_rxv}, 8'b1110_1110);
    chk("rst_rxd", a_rxd, 0);
    chk("rst_errs", {a_perr, a_ferr, a_ovr, b_perr, b_ferr, b_ovr}, 0);
    rst_n = 1'b1;
    tick(5);

    // TX waveform of 0xA5 with loopback
    a_txd = 8'hA5; a_txv = 1'b1;
    tick(1);
    a_txv = 1'b0;
    chk("tx_lat_n", a_tx, 1);
    tick(1);
    chk("tx_lat_n1", a_tx, 1);
    tick(1);
    chk("tx_lat_n2", a_tx, 0);
    fr = {1'b1, 8'hA5, 1'b0};
    tick(50);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_a5_bit%0d", i), a_tx, fr[i]);
      tick(DIV);
    end
    wait_rx(0, "lb_a5_valid", 1500);
    pop(0, "lb_a5_data", 8'hA5);
    chk("lb_a5_errs", n_perr_a + n_ferr_a + n_ovr_a, 0);

    // framing error, then recovery
    loop = 1'b0;
    tick(5);
    send(0, {1'b0, 8'h66, 1'b0});
    tick(200);
    chk("ferr_pulse", n_ferr_a, 1);
    chk("ferr_nopush", a_rxv, 0);
    send(0, {1'b1, 8'h5A, 1'b0});
    wait_rx(0, "ferr_recover_valid", 500);
    pop(0, "ferr_recover_data", 8'h5A);
    chk("ferr_once", n_ferr_a, 1);

    // 30-cycle glitch: false start
    drv_a = 1'b0; tick(30); drv_a = 1'b1;
    tick(1500);
    chk("glitch_nopush", a_rxv, 0);
    chk("glitch_noerr", n_ferr_a + n_perr_a + n_ovr_a, 1);

    // fill RX FIFO (pointers wrap), ninth character overruns
    for (int i = 0; i < 9; i++) begin
      send(0, {1'b1, 8'(8'h10 + i), 1'b0});
      tick(5);
      chk($sformatf("rts_after_%0d", i + 1), a_rts, (i <= 5) ? 1 : 0);
    end
    chk("ovr_pulse", n_ovr_a, 1);
    for (int k = 0; k < 8; k++) pop(0, $sformatf("ovr_order_%0d", k), 8'(8'h10 + k));
    chk("ovr_drained", a_rxv, 0);
    tick(3);
    chk("rts_restored", a_rts, 1);

    // CTS flow control
    loop = 1'b1; a_cts = 1'b0;
    tick(5);
    a_txv = 1'b1; a_txd = 8'h11; tick(1);
    a_txd = 8'h22; tick(1);
    a_txd = 8'h33; tick(1);
    a_txv = 1'b0;
    l0 = lowcnt;
    tick(300);
    chk("cts_hold", lowcnt - l0, 0);
    a_cts = 1'b1;
    wait_tx_low("cts_start");
    tick(950);
    chk("cts_f1_stop", a_tx, 1);
    tick(100);
    chk("cts_f2_gapfree", a_tx, 0);
    tick(250);
    a_cts = 1'b0;
    tick(650);
    chk("cts_f2_stop", a_tx, 1);
    tick(100);
    chk("cts_f3_held", a_tx, 1);
    wait_rx(0, "cts_rx1_valid", 100);
    pop(0, "cts_rx1", 8'h11);
    pop(0, "cts_rx2", 8'h22);
    chk("cts_rx_only2", a_rxv, 0);
    a_cts = 1'b1;
    wait_tx_low("cts_f3_start");
    tick(1000);
    wait_rx(0, "cts_rx3_valid", 100);
    chk("cts_rx3", a_rxd, 8'h33);

    // asynchronous reset mid-frame on TX and RX
    a_txv = 1'b1; a_txd = 8'h00; tick(1);
    a_txd = 8'h77; tick(1);
    a_txv = 1'b0;
    tick(400);
    chk("pre_rst_tx_low", a_tx, 0);
    chk("pre_rst_rxv", a_rxv, 1);
    pe = n_perr_a; fe = n_ferr_a; ov = n_ovr_a;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {a_tx, a_rts, a_txr, a_rxv}, 4'b1110);
    chk("rst_async_rxd", a_rxd, 0);
    tick(3);
    rst_n = 1'b1;
    l0 = lowcnt;
    tick(1200);
    chk("post_rst_tx_idle", lowcnt - l0, 0);
    chk("post_rst_rx_empty", a_rxv, 0);
    a_txd = 8'h3C; a_txv = 1'b1; tick(1); a_txv = 1'b0;
    wait_rx(0, "post_rst_valid", 1500);
    pop(0, "post_rst_3c", 8'h3C);
    chk("post_rst_noerr", (n_perr_a - pe) + (n_ferr_a - fe) + (n_ovr_a - ov), 0);

    // 7E1 parity: 0x35 has even parity 0
    send(1, {1'b1, 1'b1, 7'h35, 1'b0});
    wait_rx(1, "par_bad_valid", 200);
    chk("par_bad_pulse", n_perr_b, 1);
    pop(1, "par_bad_data", 8'h35);
    send(1, {1'b1, 1'b0, 7'h35, 1'b0});
    wait_rx(1, "par_ok_valid", 200);
    chk("par_ok_nopulse", n_perr_b, 1);
    pop(1, "par_ok_data", 8'h35);
    chk("par_other_errs", n_ferr_b + n_ovr_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
